// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: round-robin packet arbiter placing N AXI-Stream requesters
// in front of one shared stream port. A grant lasts for a whole packet, from the
// first beat to the tlast beat. The data path is a combinational mux and holds no
// data.
//
// Optional feature: define STREAM_ARB_NO_BUBBLE_EN to re-arbitrate on the tlast beat.
// This removes the single IDLE cycle between back-to-back packets.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no owner; outputs quiet; next valid requester picked round-robin
// BUSY  | requester 'grant' owns the output until its tlast beat transfers
module stream_rr_arbiter #(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [N*W-1:0]       in_tdata,
  input  logic [N-1:0]         in_tvalid,
  input  logic [N-1:0]         in_tlast,
  output logic [N-1:0]         in_tready,
  output logic [W-1:0]         out_tdata,
  output logic                 out_tvalid,
  output logic                 out_tlast,
  input  logic                 out_tready,
  output logic [$clog2(N)-1:0] grant_id
);

  localparam int GW = $clog2(N);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] grant, grant_nxt;
  logic [GW-1:0] last_grant, last_grant_nxt;
  logic [GW-1:0] pick_base;
  logic [GW-1:0] pick;
  logic          pick_valid;
  logic [GW:0]   scan_sum;
  logic [GW-1:0] scan_idx;
  logic [W-1:0]  lane [N];
  logic          busy;
  logic          xfer;

  for (genvar i = 0; i < N; i++) begin : g_lane
    assign lane[i] = in_tdata[i*W +: W];
  end

  assign busy = (state == BUSY);

  // Round-robin scan base: the previous owner, or the current owner on a tlast beat.
`ifdef STREAM_ARB_NO_BUBBLE_EN
  always_comb begin
    pick_base = busy ? grant : last_grant;
  end
`else
  always_comb begin
    pick_base = last_grant;
  end
`endif

  // Scan from pick_base+1 and wrap modulo N, so the result stays below N even when N is not a power of two.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    scan_sum   = '0;
    scan_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      scan_sum = {1'b0, pick_base} + (GW+1)'(k);
      if (scan_sum >= (GW+1)'(N)) begin
        scan_sum = scan_sum - (GW+1)'(N);
      end
      scan_idx = scan_sum[GW-1:0];
      if (!pick_valid && in_tvalid[scan_idx]) begin
        pick       = scan_idx;
        pick_valid = 1'b1;
      end
    end
  end

  // Combinational data path from the owner to the shared port, gated by BUSY.
  always_comb begin
    in_tready        = '0;
    in_tready[grant] = busy & out_tready;
    out_tdata        = lane[grant];
    out_tvalid       = busy & in_tvalid[grant];
    out_tlast        = busy & in_tlast[grant];
  end

  assign xfer     = out_tvalid & out_tready;
  assign grant_id = grant;

  // Next-state logic: arbitrate in IDLE, then hold the grant until the tlast beat transfers.
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          grant_nxt = pick;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (xfer && out_tlast) begin
          last_grant_nxt = grant;
`ifdef STREAM_ARB_NO_BUBBLE_EN
          if (pick_valid) begin
            grant_nxt = pick;
          end else begin
            state_nxt = IDLE;
          end
`else
          state_nxt = IDLE;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State registers. After reset last_grant = N-1, so requester 0 has first priority.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(N-1);
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
    end
  end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Testbench for stream_rr_arbiter (N=4, W=32).
// The reference model tracks the owner and previous owner as integers and picks
// the next owner with modulo arithmetic. Each requester has a queue of pending
// beats and a queue of expected beats.
module tb_stream_rr_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int GW = $clog2(N);
`ifdef STREAM_ARB_NO_BUBBLE_EN
  localparam int EXP_GAP = 0;
`else
  localparam int EXP_GAP = 1;
`endif

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [N*W-1:0] in_tdata;
  logic [N-1:0]  in_tvalid;
  logic [N-1:0]  in_tlast;
  logic [N-1:0]  in_tready;
  logic [W-1:0]  out_tdata;
  logic          out_tvalid;
  logic          out_tlast;
  logic          out_tready;
  logic [GW-1:0] grant_id;

  always #5 aclk = ~aclk;

  stream_rr_arbiter #(.N(N), .W(W)) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .in_tdata   (in_tdata),
    .in_tvalid  (in_tvalid),
    .in_tlast   (in_tlast),
    .in_tready  (in_tready),
    .out_tdata  (out_tdata),
    .out_tvalid (out_tvalid),
    .out_tlast  (out_tlast),
    .out_tready (out_tready),
    .grant_id   (grant_id)
  );

  beat_t    pq [N][$];
  beat_t    sb [N][$];
  logic [N-1:0] drop;
  int       rate;
  int       ready_mode;
  int       m_owner;
  int       m_last;
  int       grant_log [$];
  int       pkt_owner;
  int       gap;
  bit       gap_armed;
  bit       gap_en;
  int       n_chk = 0;
  int       n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int rr_from(input int base, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      if (v[(base + k) % N]) return (base + k) % N;
    end
    return -1;
  endfunction

  function automatic int pending();
    int s;
    s = (m_owner >= 0) ? 1 : 0;
    for (int i = 0; i < N; i++) s += pq[i].size();
    return s;
  endfunction

  task automatic push_beat(input int r, input logic [W-1:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    pq[r].push_back(b);
    sb[r].push_back(b);
  endtask

  task automatic push_pkt(input int r, input int len);
    for (int j = 0; j < len; j++) push_beat(r, $urandom, (j == len - 1));
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (pq[i].size() == 0 || drop[i]) in_tvalid[i] = 1'b0;
      else if (!in_tvalid[i]) in_tvalid[i] = ($urandom_range(0, 99) < rate);
      if (pq[i].size() > 0) begin
        in_tdata[i*W +: W] = pq[i][0].data;
        in_tlast[i]        = pq[i][0].last;
      end else begin
        in_tdata[i*W +: W] = $urandom;
        in_tlast[i]        = 1'($urandom_range(0, 1));
      end
    end
    case (ready_mode)
      0:       out_tready = 1'b1;
      1:       out_tready = ~out_tready;
      default: out_tready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic check_and_model();
    logic [N-1:0] exp_rdy;
    bit    xfer;
    int    o;
    beat_t b;
    o = m_owner;
    if (o < 0) begin
      chk("idle_tvalid", out_tvalid, 0);
      chk("idle_tready", in_tready, 0);
    end else begin
      exp_rdy    = '0;
      exp_rdy[o] = out_tready;
      chk("grant_id", grant_id, o);
      chk("busy_tvalid", out_tvalid, in_tvalid[o]);
      chk("busy_tready", in_tready, exp_rdy);
      if (in_tvalid[o]) begin
        chk("tdata", out_tdata, pq[o][0].data);
        chk("tlast", out_tlast, pq[o][0].last);
      end
    end
    if (out_tvalid && out_tready) begin
      if (pkt_owner >= 0) chk("interleave", grant_id, pkt_owner);
      if (sb[grant_id].size() == 0) begin
        chk("sb_nonempty", sb[grant_id].size(), 1);
      end else begin
        b = sb[grant_id].pop_front();
        chk("sb_data", out_tdata, b.data);
        chk("sb_last", out_tlast, b.last);
      end
      pkt_owner = out_tlast ? -1 : int'(grant_id);
      if (gap_en && gap_armed) chk("gap", gap, EXP_GAP);
      gap_armed = out_tlast;
      gap       = 0;
    end else if (gap_armed) begin
      gap++;
    end
    xfer = (o >= 0) && in_tvalid[o] && out_tready;
    if (o < 0) begin
      m_owner = rr_from(m_last, in_tvalid);
      if (m_owner >= 0) grant_log.push_back(m_owner);
    end else if (xfer) begin
      b = pq[o].pop_front();
      if (b.last) begin
        m_last  = o;
        m_owner = -1;
`ifdef STREAM_ARB_NO_BUBBLE_EN
        m_owner = rr_from(o, in_tvalid);
        if (m_owner >= 0) grant_log.push_back(m_owner);
`endif
      end
    end
  endtask

  task automatic cycle();
    drive_inputs();
    #1;
    check_and_model();
    @(negedge aclk);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic drain(input int budget);
    while (pending() > 0 && budget > 0) begin
      cycle();
      budget--;
    end
    chk("drain_left", pending(), 0);
  endtask

  task automatic chk_log(input string tag, input int exp_q[$]);
    chk({tag, "_len"}, grant_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < grant_log.size(); i++)
      chk(tag, grant_log[i], exp_q[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_tdata   = '0;
    in_tvalid  = '0;
    in_tlast   = '0;
    out_tready = 1'b1;
    drop       = '0;
    rate       = 100;
    ready_mode = 0;
    m_owner    = -1;
    m_last     = N - 1;
    pkt_owner  = -1;
    gap        = 0;
    gap_armed  = 0;
    gap_en     = 0;
    aresetn    = 1'b0;

    repeat (2) @(negedge aclk);
    #1;
    chk("reset_tvalid", out_tvalid, 0);
    chk("reset_tready", in_tready, 0);
    chk("reset_grant", grant_id, 0);
    @(negedge aclk);
    aresetn = 1'b1;

    // Single requester, 3-beat packet on requester 2.
    push_beat(2, 32'h4142_4344, 1'b0);
    push_beat(2, 32'h4546_4748, 1'b0);
    push_beat(2, 32'h494A_4B4C, 1'b1);
    drain(20);
    chk_log("t1_grant", '{2});

    // Single-beat packet on requester 3 leaves last_grant = 3.
    grant_log.delete();
    push_beat(3, 32'hCAFE_0003, 1'b1);
    drain(10);
    chk_log("single_beat_grant", '{3});

    // All requesters continuously valid with 2-beat packets.
    grant_log.delete();
    gap_en    = 1;
    gap_armed = 0;
    for (int p = 0; p < 2; p++)
      for (int r = 0; r < N; r++) push_pkt(r, 2);
    drain(60);
    gap_en    = 0;
    gap_armed = 0;
    chk_log("all_valid_order", '{0, 1, 2, 3, 0, 1, 2, 3});

    // Requesters 1 and 3 with last_grant = 3.
    grant_log.delete();
    push_pkt(1, 2);
    push_pkt(3, 2);
    drain(30);
    chk_log("r1_r3_order", '{1, 3});

    // Owner 0 mid-packet, requester 1 arrives, out_tready toggling.
    grant_log.delete();
    ready_mode = 1;
    push_pkt(0, 4);
    run(2);
    push_pkt(1, 3);
    drain(40);
    ready_mode = 0;
    chk_log("toggle_order", '{0, 1});

    // Owner 2 drops valid for 5 cycles mid-packet while requester 0 waits.
    grant_log.delete();
    push_pkt(2, 4);
    push_pkt(0, 2);
    run(2);
    drop[2] = 1'b1;
    repeat (5) begin
      drive_inputs();
      #1;
      chk("drop_tvalid", out_tvalid, 0);
      chk("drop_grant", grant_id, 2);
      check_and_model();
      @(negedge aclk);
    end
    drop[2] = 1'b0;
    drain(40);
    chk_log("drop_order", '{2, 0});

    // Randomized traffic with random back-pressure.
    rate       = 60;
    ready_mode = 2;
    for (int it = 0; it < 40; it++) begin
      push_pkt($urandom_range(0, N - 1), $urandom_range(1, 5));
      run($urandom_range(5, 20));
    end
    drain(2000);
    rate       = 100;
    ready_mode = 0;

    // Reset asserted between clock edges in the middle of a packet.
    push_pkt(1, 6);
    run(3);
    @(posedge aclk);
    #3;
    chk("pre_rst_tvalid", out_tvalid, 1);
    aresetn = 1'b0;
    #1;
    chk("rst_tvalid", out_tvalid, 0);
    chk("rst_tready", in_tready, 0);
    for (int i = 0; i < N; i++) begin
      pq[i].delete();
      sb[i].delete();
    end
    in_tvalid = '0;
    m_owner   = -1;
    m_last    = N - 1;
    pkt_owner = -1;
    gap_armed = 0;
    @(negedge aclk);
    @(negedge aclk);
    #2;
    aresetn = 1'b1;
    @(negedge aclk);
    grant_log.delete();
    for (int r = 0; r < N; r++) push_pkt(r, 1);
    drain(40);
    chk_log("post_rst_order", '{0, 1, 2, 3});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
